// File: rtl/ahb_ap_pkg.sv
// Shared types and constants for the JTAG access-port AHB-Lite master.
package ahb_ap_pkg;

   localparam int unsigned InstrW      = 41;
   localparam int unsigned InstrRnw    = 0;
   localparam int unsigned InstrSelLsb = 1;
   localparam int unsigned InstrPayLsb = 9;

   localparam int unsigned CswAutoInc = 4;
   localparam int unsigned CswErr     = 5;

   localparam logic [1:0] HtransIdle   = 2'b00;
   localparam logic [1:0] HtransNonseq = 2'b10;
   localparam logic [2:0] HsizeByte    = 3'b000;
   localparam logic [2:0] HsizeHalf    = 3'b001;
   localparam logic [2:0] HsizeWord    = 3'b010;
   localparam logic [2:0] HburstSingle = 3'b000;

   typedef enum logic [1:0] {
      SelCsw  = 2'b00,
      SelTar  = 2'b01,
      SelRsvd = 2'b10,
      SelDrw  = 2'b11
   } regsel_t;

   typedef enum logic [2:0] {
      StIdle,
      StDecode,
      StAddr,
      StData,
      StResp
   } state_t;

   function automatic logic is_aligned(input logic [1:0] addr_lsb, input logic [2:0] size);
      logic ok;
      case (size)
         HsizeByte: ok = 1'b1;
         HsizeHalf: ok = ~addr_lsb[0];
         default:   ok = (addr_lsb == 2'b00);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ahb_ap_master.sv
// Executes queued access-port instructions: CSW/TAR register ops and single
// AHB-Lite transfers through DRW, returning read data and status.
module ahb_ap_master
   import ahb_ap_pkg::*;
(
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              rempty,
   input  logic [InstrW-1:0] rdata,
   output logic              rinc,
   output logic [31:0]       HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [31:0]       HWDATA,
   input  logic [31:0]       HRDATA,
   input  logic              HREADY,
   input  logic              HRESP,
   output logic [31:0]       rsp_data,
   output logic              rsp_err,
   output logic              rsp_valid,
   output logic              ahb_err,
   output logic              busy
);

   state_t      state_q, state_d;
   logic        rnw_q, rnw_d;
   regsel_t     sel_q, sel_d;
   logic [31:0] pay_q, pay_d;
   logic [31:0] tar_q, tar_d;
   logic [2:0]  size_q, size_d;
   logic        autoinc_q, autoinc_d;
   logic        err_q, err_d;
   logic        err_set, err_clr;
   logic [31:0] haddr_q, haddr_d;
   logic [31:0] hwdata_q, hwdata_d;
   logic        hwrite_q, hwrite_d;
   logic [2:0]  hsize_q, hsize_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] csw_rd;

   // Instruction bits [8:3] carry no meaning for this port.
   logic unused_rdata;
   assign unused_rdata = ^rdata[8:3];

   assign csw_rd = {26'd0, err_q, autoinc_q, 1'b0, size_q};

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q    <= StIdle;
         rnw_q      <= 1'b0;
         sel_q      <= SelCsw;
         pay_q      <= '0;
         tar_q      <= '0;
         size_q     <= HsizeWord;
         autoinc_q  <= 1'b0;
         err_q      <= 1'b0;
         haddr_q    <= '0;
         hwdata_q   <= '0;
         hwrite_q   <= 1'b0;
         hsize_q    <= HsizeWord;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rnw_q      <= rnw_d;
         sel_q      <= sel_d;
         pay_q      <= pay_d;
         tar_q      <= tar_d;
         size_q     <= size_d;
         autoinc_q  <= autoinc_d;
         err_q      <= err_d;
         haddr_q    <= haddr_d;
         hwdata_q   <= hwdata_d;
         hwrite_q   <= hwrite_d;
         hsize_q    <= hsize_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rnw_d      = rnw_q;
      sel_d      = sel_q;
      pay_d      = pay_q;
      tar_d      = tar_q;
      size_d     = size_q;
      autoinc_d  = autoinc_q;
      haddr_d    = haddr_q;
      hwdata_d   = hwdata_q;
      hwrite_d   = hwrite_q;
      hsize_d    = hsize_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      err_set    = 1'b0;
      err_clr    = 1'b0;
      rinc       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!rempty) begin
               rinc    = 1'b1;
               rnw_d   = rdata[InstrRnw];
               sel_d   = regsel_t'(rdata[InstrSelLsb +: 2]);
               pay_d   = rdata[InstrPayLsb +: 32];
               state_d = StDecode;
            end
         end
         StDecode: begin
            state_d = StIdle;
            unique case (sel_q)
               SelCsw: begin
                  if (rnw_q) begin
                     rsp_data_d = csw_rd;
                     rsp_err_d  = 1'b0;
                     state_d    = StResp;
                  end else begin
                     autoinc_d = pay_q[CswAutoInc];
                     err_clr   = pay_q[CswErr];
                     if (pay_q[2:0] > HsizeWord) begin
                        size_d  = HsizeWord;
                        err_set = 1'b1;
                     end else begin
                        size_d = pay_q[2:0];
                     end
                  end
               end
               SelTar: begin
                  if (rnw_q) begin
                     rsp_data_d = tar_q;
                     rsp_err_d  = 1'b0;
                     state_d    = StResp;
                  end else begin
                     tar_d = pay_q;
                  end
               end
               SelDrw: begin
                  if (!is_aligned(tar_q[1:0], size_q)) begin
                     err_set = 1'b1;
                     if (rnw_q) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = StResp;
                     end
                  end else begin
                     haddr_d  = tar_q;
                     hwrite_d = ~rnw_q;
                     hsize_d  = size_q;
                     hwdata_d = pay_q;
                     state_d  = StAddr;
                  end
               end
               SelRsvd: err_set = 1'b1;
            endcase
         end
         StAddr: begin
            if (HREADY) state_d = StData;
         end
         StData: begin
            if (HREADY) begin
               // An errored access leaves TAR where it was so it can be retried.
               if (HRESP) begin
                  err_set = 1'b1;
               end else if (autoinc_q) begin
                  tar_d = tar_q + (32'd1 << size_q);
               end
               if (rnw_q) begin
                  rsp_data_d = HRDATA;
                  rsp_err_d  = HRESP;
                  state_d    = StResp;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Set has priority over write-1-to-clear.
      if (err_set) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   assign HTRANS    = (state_q == StAddr) ? HtransNonseq : HtransIdle;
   assign HBURST    = HburstSingle;
   assign HADDR     = haddr_q;
   assign HWRITE    = hwrite_q;
   assign HSIZE     = hsize_q;
   assign HWDATA    = hwdata_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_valid = (state_q == StResp);
   assign ahb_err   = err_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: doc/ahb_ap_master.md
# ahb_ap_master

Executes the 41-bit access-port instructions shifted in over JTAG and queued in the command FIFO. Pops one instruction at a time, updates its internal CSW/TAR registers or issues a single AHB-Lite transfer, and returns read data/status to the JTAG side. It runs in the system clock domain, downstream of the command FIFO's read port and upstream of the AHB interconnect.

## Interface
- No parameters; all widths are fixed in `ahb_ap_pkg`.
- `HCLK` in 1: system clock.
- `HRESET` in 1: synchronous, active-high reset.
- `rempty` in 1: command FIFO empty.
- `rdata` in 41: FIFO head instruction, valid whenever `rempty`=0 (show-ahead).
- `rinc` out 1: pop the FIFO head.
- `HADDR` out 32, `HTRANS` out 2, `HWRITE` out 1, `HSIZE` out 3, `HBURST` out 3, `HWDATA` out 32: AHB-Lite master outputs.
- `HRDATA` in 32, `HREADY` in 1, `HRESP` in 1: AHB-Lite master inputs.
- `rsp_data` out 32: read result.
- `rsp_err` out 1: error flag for this response.
- `rsp_valid` out 1: one-cycle strobe qualifying `rsp_data`/`rsp_err`.
- `ahb_err` out 1: sticky error, also CSW[5].
- `busy` out 1: state ≠ IDLE.

## Operation
- Instruction fields:
  - [0] RnW (1 = read).
  - [2:1] register select: 00 CSW, 01 TAR, 11 DRW, 10 reserved.
  - [8:3] ignored.
  - [40:9] payload.
- CSW bits:
  - [2:0] HSIZE; legal values 000, 001, 010.
  - [4] auto-increment.
  - [5] sticky error, write-1-to-clear.
  - Other bits read as 0.
- CSW write: loads [2:0] and [4]; clears [5] if payload[5]=1. An illegal size value is stored as 010 and sets the error.
- TAR write: TAR ← payload.
- CSW/TAR read: `rsp_data` ← register value, `rsp_err`=0. No AHB transfer.
- DRW write/read issues one AHB transfer:
  - HTRANS NONSEQ, HBURST SINGLE, HSIZE from CSW, HADDR = TAR.
  - HWDATA = payload (unshifted).
  - A read returns HRDATA unshifted in `rsp_data`.
- Unaligned TAR for the current size: no AHB transfer; error set; a read returns `rsp_data`=0, `rsp_err`=1.
- Auto-increment: after every DRW access that completes without error, TAR += 1<<size, modulo 2^32. TAR is not incremented after an error.
- Reserved select: instruction discarded, error set, no response.
- FSM states:
  - IDLE: if `rempty`=0, `rinc`=1 and latch `rdata` → DECODE.
  - DECODE: register ops and error cases execute here → RESP if a response is due, else IDLE. Aligned DRW → ADDR.
  - ADDR: drive the address phase; on HREADY=1 → DATA.
  - DATA: HTRANS=IDLE, HWDATA held. On HREADY=1, sample HRDATA/HRESP → RESP if read, else IDLE.
  - RESP: `rsp_valid`=1 → IDLE.
- Error handling: HRESP=1 sampled with HREADY=1 sets the error and, for a read, `rsp_err`. The first ERROR cycle (HREADY=0) only waits.
- Reset values:
  - `rinc`, `rsp_valid`, `rsp_err`, `ahb_err`, `busy`: 0.
  - `HTRANS`: IDLE. `HADDR`, `HWDATA`, `rsp_data`, TAR: 0.
  - `HSIZE`/CSW size: 010. `HBURST`: 000. `HWRITE`: 0.
  - CSW[4]=0; state IDLE.
- HRESET mid-transfer aborts to IDLE with no response. The popped instruction is lost.

## Timing
- Cycle T is the IDLE pop cycle.
- Register op: register value visible at T+2 (set in DECODE at T+1). A read response strobes at T+2. The next pop is no earlier than T+2 (write) or T+3 (read).
- DRW with zero wait states: address phase at T+2, data phase at T+3. A read `rsp_valid` at T+4. The next pop is at T+4 (write) or T+5 (read).
- Each wait state (HREADY=0) extends the current phase by one cycle. Address-phase outputs stay stable while HREADY=0.
- `rinc` is asserted only in IDLE with `rempty`=0, one cycle per instruction.
- An error-set event and a W1C clear in the same cycle: the set wins.

## Structure
- `ahb_ap_pkg` holds:
  - `regsel_t` enum, `state_t` enum.
  - Instruction field positions and CSW bit positions.
  - HTRANS/HSIZE/HBURST constants.
  - The alignment function.
- Single module; no sub-module.

## Test plan
- Reset defaults: reset, then read CSW → `rsp_data`=0x00000002 at T+2, AHB idle.
- Write round trip: write TAR=0x20000000, CSW size 010 with autoinc, DRW write 0xDEADBEEF → one NONSEQ write at 0x20000000; TAR reads 0x20000004.
- Byte auto-increment and wrap: size 000, TAR=0xFFFFFFFF, DRW read with HRDATA=0x000000A5 → `rsp_data`=0x000000A5; TAR reads 0x00000000.
- Wait states and error:
  - Three HREADY=0 cycles in the data phase → response delayed exactly 3 cycles.
  - Two-cycle HRESP error → `rsp_err`=1, `ahb_err`=1, TAR not incremented.
  - CSW write with payload[5]=1 → `ahb_err` clears.
- Unaligned and reserved:
  - TAR=0x1002 with size 010, DRW read → no HTRANS NONSEQ, `rsp_err`=1.
  - Reserved select → popped, error set, no `rsp_valid`.
- Reset mid-transfer: HRESET during the ADDR phase → next cycle HTRANS=IDLE, `busy`=0, no `rsp_valid`; the next FIFO entry executes normally.
